// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: {Cout,S} = A + B + Cin, one full-adder slice per clock, LSB first.
// State | meaning
// IDLE  | waiting for start; S/Cout hold last result
// SHIFT | WIDTH shift edges through the slice, then one settle edge into DONE
// DONE  | done pulse; start here is accepted back-to-back
module serial_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH:0]   s_ext;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // Sum bits enter at the MSB so that after WIDTH shifts the LSB lands in S[0].
  assign s_ext     = {sum_bit, s_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != CNT_END) begin
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          c_d   = carry_nxt;
          s_d   = s_ext[WIDTH:1];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cout_d = carry_nxt;
            busy_d = 1'b0;
          end
        end else begin
          // Settle edge: result is complete, raise done next cycle.
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Scoreboard bench for serial_adder_4bit: stimulus pushes A+B+Cin, a monitor pops on done.
module tb_serial_adder_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_v;

  serial_adder_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a_in), .B(b_in), .Cin(cin),
    .S(s), .Cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [W:0] model(input int a, input int b, input int c);
    int sum;
    sum = (a + b + c) % (1 << (W + 1));
    return sum[W:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=S%0d/C%0d required=no_done", s, cout);
      end else begin
        exp_v = exp_q.pop_front();
        check("sum_cout", {27'd0, cout, s}, {27'd0, exp_v});
        check("busy_during_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic run_op(input int a, input int b, input int c, output int lat, output int bcyc);
    @(negedge clk);
    a_in = W'(a); b_in = W'(b); cin = c[0]; start = 1'b1;
    exp_q.push_back(model(a, b, c));
    lat = 0; bcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcyc++;
      if (done) begin lat = i; break; end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done_within_20");
    end
  endtask

  int lat, bcyc, ndone, p1, p2, p3, cyc;
  logic [W:0] held;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_S", {28'd0, s}, 32'd0);
    check("rst_Cout", {31'd0, cout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    run_op(5, 1, 0, lat, bcyc);
    check("latency_5p1", lat, W + 2);
    check("busy_cycles", bcyc, W);
    repeat (4) @(negedge clk);
    check("hold_S_idle", {28'd0, s}, 32'd6);

    run_op(9, 6, 0, lat, bcyc);
    run_op(15, 1, 0, lat, bcyc);
    run_op(8, 7, 1, lat, bcyc);
    run_op(0, 0, 1, lat, bcyc);
    check("latency_cin", lat, W + 2);

    // A second request raised mid-SHIFT must be dropped.
    @(negedge clk);
    a_in = 4'd3; b_in = 4'd2; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(3, 2, 0));
    @(negedge clk); a_in = 4'd11; b_in = 4'd4;
    @(negedge clk); a_in = 4'd7;  b_in = 4'd9; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignored_start_dones", ndone, 1);

    // Held start: back-to-back operations through DONE.
    @(negedge clk);
    a_in = 4'd11; b_in = 4'd4; cin = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back(model(11, 4, 0));
    ndone = 0; p1 = 0; p2 = 0; p3 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) p1 = i;
        if (ndone == 2) p2 = i;
        if (ndone == 3) begin p3 = i; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    check("b2b_first", p1, W + 2);
    check("b2b_gap1", p2 - p1, W + 2);
    check("b2b_gap2", p3 - p2, W + 2);
    repeat (8) @(negedge clk);

    // Reset in the second SHIFT cycle discards the operation.
    @(negedge clk);
    a_in = 4'd5; b_in = 4'd5; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_S", {28'd0, s}, 32'd0);
    check("midrst_Cout", {31'd0, cout}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2, 2, 0, lat, bcyc);
    check("after_rst_latency", lat, W + 2);

    for (int n = 0; n < 40; n++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      rc = int'($urandom_range(0, 1));
      run_op(ra, rb, rc, lat, bcyc);
      check("rand_latency", lat, W + 2);
      held = model(ra, rb, rc);
      cyc = int'($urandom_range(0, 3));
      repeat (cyc) @(negedge clk);
      if (cyc > 0) check("rand_hold", {27'd0, cout, s}, {27'd0, held});
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
